// File: rtl/riscv_pkg.sv
// Shared core definitions: ISA constants, default datapath width and the
// instruction-fetch FSM encoding.
package riscv_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a fetch response that could not
// enter IF/ID in the cycle it arrived. Clear beats load, load beats drain.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;

  always_comb begin
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      buf_instr_d = instr_i;
      buf_pc_d    = pc_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Only the occupancy flag needs reset; the payload is qualified by it.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign valid_o = valid_q;
  assign instr_o = buf_instr_q;
  assign pc_o    = buf_pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests, skid
// buffer for stalled responses, and the IF/ID pipeline register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;

  logic            rsp, deliver, fire, skid_load, skid_drain;
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  // A response goes straight to IF/ID only when nothing holds IF/ID and no
  // older instruction sits in the skid; otherwise it is parked in the skid.
  always_comb begin
    rsp        = (state_q == FETCH_WAIT) && imem_rvalid;
    deliver    = rsp && !pc_src_e && !stall && !flush_d && !skid_valid;
    skid_load  = rsp && !pc_src_e && !deliver;
    skid_drain = skid_valid && !pc_src_e && !stall && !flush_d;
    case (state_q)
      FETCH_REQ:  imem_req = !stall && !skid_valid && !pc_src_e;
      FETCH_WAIT: imem_req = deliver;
      default:    imem_req = 1'b0;
    endcase
    fire = imem_req && imem_gnt;
  end

  assign imem_addr = pc_f_q;

  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    req_pc_d = req_pc_q;
    if (fire) begin
      pc_f_d   = pc_f_q + PC_STEP;
      req_pc_d = pc_f_q;
    end
    if (pc_src_e) begin
      pc_f_d = pc_target_e & ALIGN_MASK;
      // An in-flight response that has not returned yet must be swallowed.
      if ((state_q == FETCH_WAIT || state_q == FETCH_DROP) && !imem_rvalid)
        state_d = FETCH_DROP;
      else
        state_d = FETCH_REQ;
    end else begin
      case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ:  if (fire) state_d = FETCH_WAIT;
        FETCH_WAIT: if (rsp) state_d = fire ? FETCH_WAIT : FETCH_REQ;
        FETCH_DROP: if (imem_rvalid) state_d = FETCH_REQ;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (pc_src_e || flush_d || !stall) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
      if (!pc_src_e && !flush_d) begin
        if (deliver) begin
          ifid_instr_d = imem_rdata;
          ifid_pc_d    = req_pc_q;
          ifid_pc4_d   = req_pc_q + PC_STEP;
          ifid_valid_d = 1'b1;
        end else if (skid_valid) begin
          ifid_instr_d = skid_instr;
          ifid_pc_d    = skid_pc;
          ifid_pc4_d   = skid_pc + PC_STEP;
          ifid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_IDLE;
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
    req_pc_q <= req_pc_d;
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (pc_src_e),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted scenarios plus a randomized run, all checked
// against an in-order instruction-stream scoreboard and a simple imem model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  bit          pend_valid = 0;
  logic [31:0] pend_addr  = '0;
  int          pend_cnt   = 0;
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          scramble   = 0;
  bit          stale_rsp  = 0;

  // stream scoreboard state
  logic [31:0] exp_pc    = RESET_PC;
  bit          mdl_valid = 0;
  logic [31:0] mdl_pc    = '0;
  int          n_instr   = 0;

  logic        req_s;
  logic [31:0] addr_s;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? (a ^ 32'hDEAD_BEEF) : a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_d(input string tag, input bit v, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'b0, valid_d}, {31'b0, v});
    check_eq({tag, "_pc"},    pc_d,       v ? pc : 32'h0);
    check_eq({tag, "_pc4"},   pc_plus4_d, v ? pc + 32'd4 : 32'h0);
    check_eq({tag, "_instr"}, instr_d,    v ? mem_word(pc) : NOP_INSTR);
  endtask

  // One clock: entered at negedge with inputs driven, returns at next negedge.
  task automatic tick();
    logic        fire, rst_s, st_s, fl_s, rd_s;
    logic [31:0] tgt_s;
    imem_rvalid = stale_rsp || (pend_valid && pend_cnt == 1);
    imem_rdata  = stale_rsp ? 32'hBAD0_0000 : (imem_rvalid ? mem_word(pend_addr) : 32'h0);
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    fire   = imem_req && imem_gnt;
    if (req_s) begin
      check_eq("one_outstanding", {31'b0, pend_valid && pend_cnt != 1}, 32'h0);
      check_eq("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
    end
    rst_s = reset; st_s = stall; fl_s = flush_d; rd_s = pc_src_e; tgt_s = pc_target_e;
    @(posedge clk);
    #1;
    if (rst_s) begin
      pend_valid = 0;
    end else begin
      if (pend_valid) begin
        if (pend_cnt == 1) pend_valid = 0;
        else pend_cnt--;
      end
      if (fire) begin
        pend_valid = 1;
        pend_addr  = addr_s;
        pend_cnt   = $urandom_range(lat_max, lat_min);
      end
    end
    if (rst_s) begin
      exp_pc = RESET_PC; mdl_valid = 0;
      check_d("reset", 0, 32'h0);
    end else if (rd_s) begin
      exp_pc = tgt_s & ~32'h3; mdl_valid = 0;
      check_d("redirect", 0, 32'h0);
    end else if (fl_s) begin
      mdl_valid = 0;
      check_d("flush", 0, 32'h0);
    end else if (st_s) begin
      check_d("stall_hold", mdl_valid, mdl_pc);
    end else if (valid_d) begin
      check_d("stream", 1, exp_pc);
      mdl_valid = 1; mdl_pc = exp_pc;
      exp_pc += 32'd4;
      n_instr++;
    end else begin
      mdl_valid = 0;
      check_d("bubble", 0, 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0; imem_gnt = 1;
    tick();
    reset = 0;
    check_eq("rst_req",  {31'b0, imem_req}, 32'h0);
    check_eq("rst_addr", imem_addr, RESET_PC);
  endtask

  task automatic wait_valid(input int bound);
    int i = 0;
    while (!valid_d && i < bound) begin tick(); i++; end
    check_eq("wait_valid", {31'b0, valid_d}, 32'h1);
  endtask

  initial begin
    reset = 1; stall = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;
    imem_gnt = 1; imem_rvalid = 0; imem_rdata = '0;
    @(negedge clk);

    // ideal memory: first valid at cycle 3, then one per cycle
    lat_min = 1; lat_max = 1; scramble = 0;
    do_reset();
    tick(); tick();
    check_eq("t1_c2_valid", {31'b0, valid_d}, 32'h0);
    tick();
    check_eq("t1_c3_valid", {31'b0, valid_d}, 32'h1);
    check_eq("t1_c3_pc", pc_d, 32'h0);
    check_eq("t1_c3_pc4", pc_plus4_d, 32'h4);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("t1_seq_pc", pc_d, 32'(4 * i));
    end

    // grant withheld for three cycles at 0x8
    do_reset();
    tick(); tick(); tick();
    imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_gap_req", {31'b0, req_s}, 32'h1);
      check_eq("t2_gap_addr", addr_s, 32'h8);
    end
    check_eq("t2_gap_valid", {31'b0, valid_d}, 32'h0);
    imem_gnt = 1;
    tick();
    check_eq("t2_resume_addr", addr_s, 32'h8);
    check_eq("t2_c7_valid", {31'b0, valid_d}, 32'h0);
    tick();
    check_eq("t2_pc8", pc_d, 32'h8);
    tick();
    check_eq("t2_pcC", pc_d, 32'hC);

    // stall while the 0x10 response arrives
    do_reset();
    repeat (6) tick();
    check_eq("t3_pre_pc", pc_d, 32'hC);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t3_stall_req", {31'b0, req_s}, 32'h0);
      check_eq("t3_stall_pc", pc_d, 32'hC);
    end
    stall = 0;
    tick();
    check_eq("t3_rel_valid", {31'b0, valid_d}, 32'h1);
    check_eq("t3_rel_pc", pc_d, 32'h10);
    tick();
    wait_valid(20);
    check_eq("t3_next_pc", pc_d, 32'h14);

    // redirect to 0x102 while waiting on a slow response
    lat_min = 3; lat_max = 3;
    do_reset();
    tick(); tick();
    pc_src_e = 1; pc_target_e = 32'h102;
    tick();
    pc_src_e = 0;
    check_eq("t4_redir_req", {31'b0, req_s}, 32'h0);
    check_eq("t4_addr", imem_addr, 32'h100);
    tick();
    check_eq("t4_drop_req", {31'b0, req_s}, 32'h0);
    tick();
    check_eq("t4_drop_req2", {31'b0, req_s}, 32'h0);
    tick();
    check_eq("t4_new_req", {31'b0, req_s}, 32'h1);
    check_eq("t4_new_addr", addr_s, 32'h100);
    wait_valid(30);
    check_eq("t4_first_pc", pc_d, 32'h100);

    // flush and stall together
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (4) tick();
    check_eq("t5_pre_addr", imem_addr, 32'hC);
    stall = 1; flush_d = 1;
    tick();
    stall = 0; flush_d = 0;
    check_eq("t5_valid", {31'b0, valid_d}, 32'h0);
    check_eq("t5_instr", instr_d, NOP_INSTR);
    check_eq("t5_addr", imem_addr, 32'hC);
    wait_valid(20);
    check_eq("t5_after_pc", pc_d, 32'h8);

    // reset during WAIT, then stale responses
    lat_min = 3; lat_max = 3;
    do_reset();
    tick(); tick();
    do_reset();
    stale_rsp = 1;
    tick(); tick();
    stale_rsp = 0;
    wait_valid(30);
    check_eq("t6_first_pc", pc_d, RESET_PC);
    check_eq("t6_first_instr", instr_d, mem_word(RESET_PC));

    // randomized traffic
    scramble = 1; lat_min = 1; lat_max = 4;
    do_reset();
    begin
      int start_n = n_instr;
      for (int c = 0; c < 4000; c++) begin
        stall    = ($urandom_range(99) < 20);
        flush_d  = ($urandom_range(99) < 3);
        pc_src_e = ($urandom_range(99) < 3);
        pc_target_e = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : $urandom;
        imem_gnt = ($urandom_range(99) < 70);
        tick();
      end
      stall = 0; flush_d = 0; pc_src_e = 0; imem_gnt = 1;
      repeat (10) tick();
      check_eq("rand_progress", {31'b0, (n_instr - start_n) >= 300}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
